l1_l2_arbiter: RTL and testbench
================================

Name: l1_l2_arbiter

Overview:
- Sits directly below the pipeline's two memory ports, behind the L1 instruction and L1 data caches.
- Arbitrates their line-fill and write-back requests onto the single L2 cache port.
- Uses a registered-grant FSM with round-robin tie-break, so neither cache starves.
- Addresses and data pass through combinationally from the granted master. Responses are steered back only to that master.

Parameters:
- ADDR_WIDTH, 16, physical address width (lc3b_word).
- LINE_WIDTH, 128, cache-line width in bits (8 words).

Ports:
- clk in 1: clock; all state updates on rising edge.
- rst_n in 1: asynchronous active-low reset.
- i_pmem_read in 1: L1I line-fill request; held high until i_pmem_resp.
- i_pmem_address in ADDR_WIDTH: L1I line address.
- i_pmem_rdata out LINE_WIDTH: line returned to L1I.
- i_pmem_resp out 1: one-cycle completion pulse to L1I.
- d_pmem_read in 1: L1D line-fill request; held until d_pmem_resp.
- d_pmem_write in 1: L1D write-back request; held until d_pmem_resp.
- d_pmem_address in ADDR_WIDTH: L1D line address.
- d_pmem_wdata in LINE_WIDTH: write-back line.
- d_pmem_rdata out LINE_WIDTH: line returned to L1D.
- d_pmem_resp out 1: one-cycle completion pulse to L1D.
- l2_read out 1: read request to L2.
- l2_write out 1: write request to L2.
- l2_address out ADDR_WIDTH: L2 address.
- l2_wdata out LINE_WIDTH: L2 write data.
- l2_rdata in LINE_WIDTH: L2 read data.
- l2_resp in 1: L2 completion pulse.
- i_wait_count out 16: cycles L1I was pending but not granted (optional feature).
- d_wait_count out 16: cycles L1D was pending but not granted (optional feature).

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, last_grant=I.
  - All outputs 0; wait counters 0.
  - Reset mid-transaction aborts the grant. An l2_resp arriving later in IDLE is ignored: no resp forwarded.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - l2_read=l2_write=0.
  - d_req = d_pmem_read | d_pmem_write.
  - Only d_req pending: next state SERVE_D.
  - Only i_pmem_read pending: next state SERVE_I.
  - Both pending: grant the master opposite to last_grant. After reset last_grant=I, so D wins the first tie.
  - Neither pending: stay IDLE.
  - Grant takes effect the next cycle, so minimum request-to-L2 latency is 1 cycle.
- SERVE_I:
  - l2_read=1, l2_write=0, l2_address=i_pmem_address, l2_wdata=0.
  - i_pmem_rdata=l2_rdata and i_pmem_resp=l2_resp (combinational).
  - On l2_resp: set last_grant=I and go to IDLE.
- SERVE_D:
  - l2_read=d_pmem_read & ~d_pmem_write.
  - l2_write=d_pmem_write. Write wins if both read and write are asserted (illegal from L1D, but defined).
  - l2_address=d_pmem_address, l2_wdata=d_pmem_wdata.
  - d_pmem_rdata=l2_rdata and d_pmem_resp=l2_resp.
  - On l2_resp: set last_grant=D and go to IDLE.
- Turnaround: the mandatory IDLE cycle after each response gives the requester a cycle to drop its request. Back-to-back service therefore costs 1 dead cycle.
- Non-granted master: resp=0 and rdata=0 at all times.
- A request that drops before its response while granted is an L1 protocol violation. The arbiter stays in SERVE until l2_resp regardless.
- l2_resp in IDLE: dropped.
- rdata outputs are 0 whenever the corresponding resp is 0.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - i_wait_count increments every cycle i_pmem_read=1 and the state is not SERVE_I.
  - d_wait_count increments every cycle d_req=1 and the state is not SERVE_D.
  - Both counters saturate at 16'hFFFF and clear only on reset.
  - This feeds the bubble/miss counters read by the execute stage.
- Undefined: both outputs tied to 16'h0000 and no counter flops are instantiated. Ports remain present.

Test Plan:
- Reset: rst_n=0 mid-SERVE_D with l2_write=1 → all outputs 0 immediately. Release rst_n, pulse l2_resp → d_pmem_resp stays 0 and state is IDLE.
- Lone I fill: i_pmem_read=1, addr 16'h3000, L2 returns 128'h0123…CDEF after 5 cycles → l2_read=1 with l2_address=16'h3000 from cycle 1. i_pmem_resp pulses 1 cycle with matching data; d_pmem_resp=0 throughout.
- D write-back: d_pmem_write=1, addr 16'h8010, wdata 128'hAAAA…AAAA → l2_write=1, l2_read=0, l2_wdata matches. d_pmem_resp is coincident with l2_resp.
- Tie after reset: i_pmem_read and d_pmem_read rise in the same cycle → D served first. After D completes, 1 IDLE cycle, then I served. Repeat with both held → grants alternate I, D, I.
- Read+write both high: d_pmem_read=d_pmem_write=1 → l2_write=1, l2_read=0.
- Perf counters (ARB_PERF_CNT_EN): I pending during a 10-cycle D transaction plus the turnaround → i_wait_count=12 (1 grant cycle + 10 SERVE_D + 1 IDLE). Forcing 70000 contention cycles → i_wait_count=16'hFFFF. Without the macro → counter outputs 0.

Source files
------------

// File: rtl/l1_l2_arbiter.sv
// Arbitrates L1I and L1D line-fill/write-back requests onto one L2 port using a
// registered-grant FSM with round-robin tie-break. Optional macro ARB_PERF_CNT_EN adds wait counters.
module l1_l2_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  l2_read,
    output logic                  l2_write,
    output logic [ADDR_WIDTH-1:0] l2_address,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic [LINE_WIDTH-1:0] l2_rdata,
    input  logic                  l2_resp,

    output logic [15:0]           i_wait_count,
    output logic [15:0]           d_wait_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    state_t state;
    state_t next_state;
    grant_t last_grant;
    logic   d_req;

    assign d_req = d_pmem_read | d_pmem_write;

    // last_grant only moves on a completed transaction, so an aborted grant never counts as a turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
        end else begin
            state <= next_state;
            if (state == SERVE_I && l2_resp) begin
                last_grant <= GRANT_I;
            end else if (state == SERVE_D && l2_resp) begin
                last_grant <= GRANT_D;
            end
        end
    end

    always_comb begin
        next_state   = state;
        l2_read      = 1'b0;
        l2_write     = 1'b0;
        l2_address   = '0;
        l2_wdata     = '0;
        i_pmem_rdata = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_rdata = '0;
        d_pmem_resp  = 1'b0;

        case (state)
            IDLE: begin
                if (i_pmem_read && d_req) begin
                    next_state = (last_grant == GRANT_I) ? SERVE_D : SERVE_I;
                end else if (d_req) begin
                    next_state = SERVE_D;
                end else if (i_pmem_read) begin
                    next_state = SERVE_I;
                end
            end
            SERVE_I: begin
                l2_read    = 1'b1;
                l2_address = i_pmem_address;
                i_pmem_resp = l2_resp;
                if (l2_resp) begin
                    i_pmem_rdata = l2_rdata;
                    next_state   = IDLE;
                end
            end
            SERVE_D: begin
                // A write-back takes priority if L1D ever raises both strobes.
                l2_read    = d_pmem_read & ~d_pmem_write;
                l2_write   = d_pmem_write;
                l2_address = d_pmem_address;
                l2_wdata   = d_pmem_wdata;
                d_pmem_resp = l2_resp;
                if (l2_resp) begin
                    d_pmem_rdata = l2_rdata;
                    next_state   = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

`ifdef ARB_PERF_CNT_EN
    logic [15:0] i_wait_q;
    logic [15:0] d_wait_q;

    // Saturating counts of cycles each master spent pending without holding the L2 port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_wait_q <= 16'h0000;
            d_wait_q <= 16'h0000;
        end else begin
            if (i_pmem_read && state != SERVE_I && i_wait_q != 16'hFFFF) begin
                i_wait_q <= i_wait_q + 16'd1;
            end
            if (d_req && state != SERVE_D && d_wait_q != 16'hFFFF) begin
                d_wait_q <= d_wait_q + 16'd1;
            end
        end
    end

    assign i_wait_count = i_wait_q;
    assign d_wait_count = d_wait_q;
`else
    assign i_wait_count = 16'h0000;
    assign d_wait_count = 16'h0000;
`endif

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Self-checking bench for l1_l2_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level model of grant ownership.
module tb_l1_l2_arbiter;

    logic         clk;
    logic         rst_n;
    logic         i_pmem_read;
    logic [15:0]  i_pmem_address;
    logic [127:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [15:0]  d_pmem_address;
    logic [127:0] d_pmem_wdata;
    logic [127:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         l2_read;
    logic         l2_write;
    logic [15:0]  l2_address;
    logic [127:0] l2_wdata;
    logic [127:0] l2_rdata;
    logic         l2_resp;
    logic [15:0]  i_wait_count;
    logic [15:0]  d_wait_count;

    l1_l2_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .i_wait_count(i_wait_count), .d_wait_count(d_wait_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: who owns the L2 port (0 none, 1 I, 2 D), who finished last, and wait totals.
    int owner     = 0;
    int last_done = 1;
    int served    = 0;
    int i_wait    = 0;
    int d_wait    = 0;

    int           l2_lat     = 3;
    bit           rand_lat   = 0;
    bit           auto_req   = 0;
    bit           auto_drop  = 1;
    bit           spur_resp  = 0;
    bit           fixed_line = 0;
    logic [127:0] resp_line  = '0;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] randLine();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [15:0] expCount(input int v);
`ifdef ARB_PERF_CNT_EN
        return 16'(v);
`else
        return 16'(v - v);
`endif
    endfunction

    task automatic modelReset();
        owner = 0; last_done = 1; served = 0; i_wait = 0; d_wait = 0;
    endtask

    task automatic clearInputs();
        i_pmem_read = 0; i_pmem_address = '0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
        l2_rdata = '0; l2_resp = 0;
    endtask

    // Holds reset across two edges, then leaves time at posedge+1 with everything idle.
    task automatic doReset();
        rst_n = 0;
        clearInputs();
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, advance the model at posedge.
    task automatic applyStimulus();
        logic [127:0] e_rd;
        int           done;
        bit           i_req, d_req;
        if (auto_req) begin
            if (!i_pmem_read && $urandom_range(2) == 0) begin
                i_pmem_read    = 1;
                i_pmem_address = 16'($urandom());
            end
            if (!(d_pmem_read || d_pmem_write) && $urandom_range(2) == 0) begin
                case ($urandom_range(7))
                    0:       begin d_pmem_read = 1; d_pmem_write = 1; end
                    1, 2, 3: begin d_pmem_read = 0; d_pmem_write = 1; end
                    default: begin d_pmem_read = 1; d_pmem_write = 0; end
                endcase
                d_pmem_address = 16'($urandom());
                d_pmem_wdata   = randLine();
            end
            spur_resp = ($urandom_range(5) == 0);
        end
        l2_resp = 0;
        if (owner != 0 && served + 1 >= l2_lat) l2_resp = 1;
        if (owner == 0 && spur_resp) l2_resp = 1;
        l2_rdata = (l2_resp && fixed_line) ? resp_line : randLine();

        @(negedge clk);
        checkOutput("l2_read", 128'(l2_read),
            128'(owner == 1 || (owner == 2 && d_pmem_read && !d_pmem_write)));
        checkOutput("l2_write", 128'(l2_write), 128'(owner == 2 && d_pmem_write));
        checkOutput("l2_address", 128'(l2_address),
            (owner == 1) ? 128'(i_pmem_address) : (owner == 2) ? 128'(d_pmem_address) : 128'(0));
        checkOutput("l2_wdata", l2_wdata, (owner == 2) ? d_pmem_wdata : 128'(0));
        e_rd = l2_resp ? l2_rdata : 128'(0);
        checkOutput("i_resp", 128'(i_pmem_resp), 128'(owner == 1 && l2_resp));
        checkOutput("i_rdata", i_pmem_rdata, (owner == 1) ? e_rd : 128'(0));
        checkOutput("d_resp", 128'(d_pmem_resp), 128'(owner == 2 && l2_resp));
        checkOutput("d_rdata", d_pmem_rdata, (owner == 2) ? e_rd : 128'(0));
        checkOutput("i_wait_count", 128'(i_wait_count), 128'(expCount(i_wait)));
        checkOutput("d_wait_count", 128'(d_wait_count), 128'(expCount(d_wait)));

        @(posedge clk);
        i_req = i_pmem_read;
        d_req = d_pmem_read || d_pmem_write;
        if (i_req && owner != 1 && i_wait < 65535) i_wait++;
        if (d_req && owner != 2 && d_wait < 65535) d_wait++;
        done = 0;
        if (owner != 0) begin
            if (l2_resp) begin
                done = owner; last_done = owner; owner = 0; served = 0;
            end else begin
                served++;
            end
        end else if (i_req && d_req) begin
            owner = (last_done == 1) ? 2 : 1;
        end else if (d_req) begin
            owner = 2;
        end else if (i_req) begin
            owner = 1;
        end
        if (rand_lat && owner != 0 && served == 0 && done == 0) l2_lat = $urandom_range(1, 6);
        if (auto_drop && done == 1) i_pmem_read = 0;
        if (auto_drop && done == 2) begin d_pmem_read = 0; d_pmem_write = 0; end
        #1;
    endtask

    task automatic runUntilIdle(input string tag, input int budget);
        int n = 0;
        while (!(owner == 0 && !i_pmem_read && !d_pmem_read && !d_pmem_write) && n < budget) begin
            applyStimulus();
            n++;
        end
        if (n >= budget) checkOutput({tag, "_timeout"}, 128'(n), 128'(0));
    endtask

    int           grant_seq[$];
    bit           prev_busy;
    logic [127:0] exp_order [4];

    initial begin
        $display("[TB] starting l1_l2_arbiter bench");
        rst_n = 0;
        clearInputs();
        #2;
        checkOutput("reset_l2_read", 128'(l2_read), 128'(0));
        checkOutput("reset_l2_address", 128'(l2_address), 128'(0));
        doReset();

        // Lone instruction fill, L2 answers on the fifth serve cycle.
        fixed_line = 1;
        resp_line  = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        l2_lat = 5;
        i_pmem_read = 1; i_pmem_address = 16'h3000;
        runUntilIdle("lone_i", 20);

        // Data write-back.
        d_pmem_write = 1; d_pmem_address = 16'h8010;
        d_pmem_wdata = {8{16'hAAAA}};
        applyStimulus();
        checkOutput("wb_wdata", l2_wdata, {8{16'hAAAA}});
        checkOutput("wb_write", 128'(l2_write), 128'(1));
        runUntilIdle("wb", 20);
        fixed_line = 0;

        // Read and write together: the write must win.
        d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 16'h0420;
        d_pmem_wdata = randLine();
        applyStimulus();
        checkOutput("rw_read", 128'(l2_read), 128'(0));
        checkOutput("rw_write", 128'(l2_write), 128'(1));
        runUntilIdle("rw", 20);

        // Reset in the middle of a write-back, then a stray response in IDLE.
        l2_lat = 100;
        d_pmem_write = 1; d_pmem_address = 16'h8010; d_pmem_wdata = {8{16'hAAAA}};
        repeat (3) applyStimulus();
        rst_n = 0;
        #1;
        checkOutput("midrst_l2_write", 128'(l2_write), 128'(0));
        checkOutput("midrst_l2_wdata", l2_wdata, 128'(0));
        checkOutput("midrst_l2_address", 128'(l2_address), 128'(0));
        doReset();
        spur_resp = 1;
        applyStimulus();
        checkOutput("stray_d_resp", 128'(d_pmem_resp), 128'(0));
        spur_resp = 0;

        // Tie straight after reset, both held: D, I, D, I; also the 12-cycle wait figure.
        doReset();
        l2_lat = 10;
        i_pmem_read = 1; i_pmem_address = 16'h1111;
        d_pmem_read = 1; d_pmem_address = 16'h2222;
        while (owner != 1 && n_cmp < 1000000) applyStimulus();
        checkOutput("i_wait_after_d", 128'(i_wait_count), 128'(expCount(12)));
        runUntilIdle("tie_first", 40);
        doReset();
        l2_lat = 2; auto_drop = 0;
        i_pmem_read = 1; i_pmem_address = 16'h1111;
        d_pmem_read = 1; d_pmem_address = 16'h2222;
        prev_busy = 0;
        for (int k = 0; k < 14; k++) begin
            if ((l2_read || l2_write) && !prev_busy)
                grant_seq.push_back((l2_address == 16'h2222) ? 2 : 1);
            prev_busy = l2_read || l2_write;
            applyStimulus();
        end
        exp_order[0] = 2; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 1;
        checkOutput("tie_grants", 128'(grant_seq.size() >= 4), 128'(1));
        for (int k = 0; k < 4 && k < grant_seq.size(); k++)
            checkOutput($sformatf("tie_order%0d", k), 128'(grant_seq[k]), exp_order[k]);
        auto_drop = 1;

        // Randomized traffic.
        doReset();
        rand_lat = 1; auto_req = 1;
        repeat (2500) applyStimulus();
        auto_req = 0; spur_resp = 0;
        runUntilIdle("random_drain", 100);
        rand_lat = 0;

        // Long contention while L2 never answers drives the I counter to saturation.
        doReset();
        i_pmem_read = 1; d_pmem_read = 1;
        repeat (70000) @(posedge clk);
        #1;
`ifdef ARB_PERF_CNT_EN
        checkOutput("i_wait_sat", 128'(i_wait_count), 128'(16'hFFFF));
        checkOutput("d_wait_sat", 128'(d_wait_count), 128'(16'h0001));
`else
        checkOutput("i_wait_off", 128'(i_wait_count), 128'(16'h0000));
        checkOutput("d_wait_off", 128'(d_wait_count), 128'(16'h0000));
`endif
        doReset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
